// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder slice: default operand width and output mode.
package full_adder_pkg;

  localparam int DEFAULT_WIDTH   = 1;
  localparam bit DEFAULT_REG_OUT = 1'b0;

endpackage : full_adder_pkg

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder: the master drives operands, the slave returns the sum.
interface full_adder_if
  import full_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             out_valid;

  modport master (
    output A, B, Cin, in_valid,
    input  S, Cout, out_valid
  );

  modport slave (
    input  A, B, Cin, in_valid,
    output S, Cout, out_valid
  );

endinterface : full_adder_if

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell; the leaf of the ripple chain built in full_adder.
module full_adder_bit
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder_bit

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from full_adder_bit cells, with an optional output register.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter bit REG_OUT = DEFAULT_REG_OUT
) (
  input  logic         clk,
  input  logic         rst,
  full_adder_if.slave  bus
);

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;
  logic             unused_s;

  // clk/rst have no loads in the combinational build
  assign unused_s   = clk ^ rst;
  assign carry_s[0] = bus.Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a  (bus.A[i]),
      .b  (bus.B[i]),
      .ci (carry_s[i]),
      .s  (sum_s[i]),
      .co (carry_s[i+1])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             valid_r;

    // Output stage: sum and carry update every edge; in_valid only tags the result
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_r     <= {WIDTH{1'b0}};
        cout_r  <= 1'b0;
        valid_r <= 1'b0;
      end else begin
        s_r     <= sum_s;
        cout_r  <= carry_s[WIDTH];
        valid_r <= bus.in_valid;
      end
    end

    assign bus.S         = s_r;
    assign bus.Cout      = cout_r;
    assign bus.out_valid = valid_r;
  end else begin : g_comb
    assign bus.S         = sum_s;
    assign bus.Cout      = carry_s[WIDTH];
    assign bus.out_valid = bus.in_valid;
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder in 1/4/8-bit combinational and 4-bit registered builds.
module tb_full_adder;

  typedef struct {
    logic [2:0] abc;
    logic       s;
    logic       cout;
  } vec1_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
  } vec4_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  full_adder_if #(.WIDTH(1)) if_w1 ();
  full_adder_if #(.WIDTH(4)) if_w4 ();
  full_adder_if #(.WIDTH(4)) if_r4 ();
  full_adder_if #(.WIDTH(8)) if_w8 ();

  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_w1 (.clk(clk), .rst(rst), .bus(if_w1));
  full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (.clk(clk), .rst(rst), .bus(if_w4));
  full_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_r4 (.clk(clk), .rst(rst), .bus(if_r4));
  full_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_w8 (.clk(clk), .rst(rst), .bus(if_w8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_r4(input string name, input logic [3:0] s, input logic cout,
                          input logic ov);
    check(name, {26'd0, if_r4.out_valid, if_r4.Cout, if_r4.S}, {26'd0, ov, cout, s});
  endtask

  initial begin
    vec1_t      t1[8];
    vec4_t      t4[7];
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] exp9;

    t1[0] = '{3'b000, 1'b0, 1'b0};
    t1[1] = '{3'b001, 1'b1, 1'b0};
    t1[2] = '{3'b010, 1'b1, 1'b0};
    t1[3] = '{3'b011, 1'b0, 1'b1};
    t1[4] = '{3'b100, 1'b1, 1'b0};
    t1[5] = '{3'b101, 1'b0, 1'b1};
    t1[6] = '{3'b110, 1'b0, 1'b1};
    t1[7] = '{3'b111, 1'b1, 1'b1};

    t4[0] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
    t4[1] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1};
    t4[2] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    t4[3] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0};
    t4[4] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    t4[5] = '{4'h3, 4'h4, 1'b1, 4'h8, 1'b0};
    t4[6] = '{4'h6, 4'h9, 1'b1, 4'h0, 1'b1};

    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    {if_w1.A, if_w1.B, if_w1.Cin, if_w1.in_valid} = 4'b0000;
    {if_w4.A, if_w4.B, if_w4.Cin, if_w4.in_valid} = 10'd0;
    {if_r4.A, if_r4.B, if_r4.Cin, if_r4.in_valid} = 10'd0;
    {if_w8.A, if_w8.B, if_w8.Cin, if_w8.in_valid} = 18'd0;

    // Exhaustive 1-bit truth table
    for (int i = 0; i < 8; i++) begin
      {if_w1.A, if_w1.B, if_w1.Cin} = t1[i].abc;
      if_w1.in_valid = i[0];
      #20;
      check($sformatf("w1_abc%b", t1[i].abc), {30'd0, if_w1.Cout, if_w1.S},
            {30'd0, t1[i].cout, t1[i].s});
      check($sformatf("w1_valid%0d", i), {31'd0, if_w1.out_valid}, {31'd0, i[0]});
    end

    // 4-bit combinational wrap and ripple cases
    for (int i = 0; i < 7; i++) begin
      if_w4.A   = t4[i].a;
      if_w4.B   = t4[i].b;
      if_w4.Cin = t4[i].cin;
      if_w4.in_valid = 1'b1;
      #20;
      check($sformatf("w4_%h_%h_%b", t4[i].a, t4[i].b, t4[i].cin),
            {27'd0, if_w4.Cout, if_w4.S}, {27'd0, t4[i].cout, t4[i].s});
    end

    // Registered build: reset state, and hold across an edge while rst is high
    @(negedge clk);
    if_r4.A = 4'h3; if_r4.B = 4'h4; if_r4.Cin = 1'b1; if_r4.in_valid = 1'b1;
    check_r4("r4_reset", 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_r4("r4_reset_hold", 4'h0, 1'b0, 1'b0);

    // Latency: inputs present before edge N appear only after edge N
    @(negedge clk);
    rst = 1'b0;
    #3;
    check_r4("r4_before_edge", 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_r4("r4_edge_n", 4'h8, 1'b0, 1'b1);
    @(negedge clk);
    if_r4.in_valid = 1'b0;
    @(posedge clk); #1;
    check_r4("r4_edge_n1", 4'h8, 1'b0, 1'b0);

    // Async reset between edges, then first capture after release
    @(negedge clk);
    if_r4.in_valid = 1'b1;
    @(posedge clk); #1;
    check_r4("r4_loaded", 4'h8, 1'b0, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_r4("r4_async_rst", 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    if_r4.A = 4'hF; if_r4.B = 4'hF; if_r4.Cin = 1'b1;
    #1;
    check_r4("r4_post_rst_pre_edge", 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_r4("r4_first_capture", 4'hF, 1'b1, 1'b1);

    // 8-bit random against a 9-bit behavioural sum; X on outputs fails the !== compare
    if_w8.in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(255, 0));
      rb = 8'($urandom_range(255, 0));
      rc = 1'($urandom_range(1, 0));
      if_w8.A = ra; if_w8.B = rb; if_w8.Cin = rc;
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      #20;
      check($sformatf("w8_rand%0d", i), {23'd0, if_w8.Cout, if_w8.S}, {23'd0, exp9});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_full_adder

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterizable binary adder. Computes S = A + B + Cin over WIDTH bits and produces a carry-out.
- Default configuration (WIDTH=1, REG_OUT=0) is the classic 1-bit combinational full adder used as the leaf arithmetic cell in the FPU datapath.
- The optional registered output stage lets the same block sit on a pipeline boundary.

Parameters:
- WIDTH, 1, operand/sum width in bits (>=1).
- REG_OUT, 0, 0 = purely combinational outputs; 1 = outputs registered on clk (1-cycle latency).

Ports:
- clk  input  1  clock; used only when REG_OUT=1.
- rst  input  1  asynchronous, active-high reset; used only when REG_OUT=1.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry-in.
- in_valid  input  1  qualifies A/B/Cin.
- S  output  WIDTH  sum bits.
- Cout  output  1  carry-out of MSB.
- out_valid  output  1  qualifies S/Cout.

Behaviour:
- Arithmetic: {Cout, S} = A + B + Cin, computed at WIDTH+1 bits with no truncation before Cout. Unsigned; no overflow flag.
- Per-bit cell: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (a_i & c_i) | (b_i & c_i). Ripple chain with c_0 = Cin and Cout = c_WIDTH.
- Wrap-around: when the sum exceeds 2^WIDTH-1, S holds the low WIDTH bits and Cout=1.
- X handling: when all inputs are known (0/1), outputs are never X/Z.
- REG_OUT=0:
  - S, Cout and out_valid are combinational functions of the inputs; out_valid = in_valid.
  - clk and rst are ignored.
  - Outputs settle within one propagation delay.
- REG_OUT=1:
  - On each rising clk edge: S, Cout and out_valid capture the adder result and in_valid. Latency is exactly 1 cycle.
  - S and Cout are updated on every edge regardless of in_valid. in_valid only qualifies out_valid.
  - rst asserted (asynchronous): S=0, Cout=0, out_valid=0 immediately.
  - Outputs hold these values while rst is high. The first capture happens on the first rising edge after rst deasserts.
  - Reset mid-operation drops the in-flight result; no partial output is produced.
- Simultaneous input change and clock edge: the value present at the edge is captured (standard flop semantics).

Decomposition:
- Package full_adder_pkg: localparam DEFAULT_WIDTH = 1. A function for the reference sum is not needed in RTL.
- Sub-module full_adder_bit: the 1-bit cell (a, b, ci -> s, co). It is instantiated WIDTH times by a generate loop in full_adder, followed by the optional output register stage.

Test Plan:
- Exhaustive, WIDTH=1, REG_OUT=0: all 8 combinations of A/B/Cin, checked 20 time units after each apply.
  - Required (S,Cout): 000->(0,0), 001->(1,0), 010->(1,0), 011->(0,1), 100->(1,0), 101->(0,1), 110->(0,1), 111->(1,1).
  - 8/8 must pass.
- WIDTH=4, REG_OUT=0, wrap: A=4'hF, B=4'h1, Cin=0 -> S=4'h0, Cout=1. Also A=4'hA, B=4'h5, Cin=1 -> S=4'h0, Cout=1 (full ripple through all bits).
- WIDTH=4, REG_OUT=1, latency: apply A=4'h3, B=4'h4, Cin=1, in_valid=1 before edge N.
  - Required: S=4'h8, Cout=0, out_valid=1 after edge N and not before.
  - Then drop in_valid; out_valid=0 after edge N+1.
- REG_OUT=1, async reset mid-operation: with S=4'h8 and out_valid=1, pulse rst between clock edges.
  - Required: S=0, Cout=0, out_valid=0 without waiting for an edge.
  - After release, the first edge captures current inputs.
- WIDTH=8, REG_OUT=0, random: 1000 random A/B/Cin vectors compared against the behavioural WIDTH+1-bit sum. Zero mismatches and no X on outputs.
